// File: rtl/cpu_writeback_unit.sv
// rtl/cpu_writeback_unit.sv - WB stage register, x1..x31 register file with bypassing read ports, retire counter
module cpu_writeback_unit #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipeline_enable,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_rd_output,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_instret
);

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] instret_q;
  logic [31:0] regs [1:31];

  // wb_valid is never set for rd=0, so x0 can never be written or forwarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      instret_q <= 32'd0;
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      if (i_pipeline_enable) begin
        wb_valid  <= (i_rd != 5'd0);
        wb_rd     <= i_rd;
        wb_data   <= i_rd_output;
        instret_q <= instret_q + 32'd1;
      end else begin
        wb_valid  <= 1'b0;
      end
      if (wb_valid && (wb_rd != 5'd0)) begin
        regs[wb_rd] <= wb_data;
      end
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] value;
    value = 32'd0;
    if (addr != 5'd0) begin
      if (BYPASS_EN && wb_valid && (wb_rd == addr)) begin
        value = wb_data;
      end else begin
        value = regs[addr];
      end
    end
    return value;
  endfunction

  always_comb begin
    o_rs1_data = read_port(i_rs1_addr);
    o_rs2_data = read_port(i_rs2_addr);
  end

  assign o_wb_valid = wb_valid;
  assign o_wb_rd    = wb_rd;
  assign o_wb_data  = wb_data;
  assign o_instret  = instret_q;

endmodule
